// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache (read) and dcache (read/write); grants are registered, so request to wait-low is 2 cycles minimum.
// Grant is held through RAM BUSY/ERROR until ACCESS or the granted requester drops its request; the loser always sees wait=1.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] starve_cnt, next_cnt;
  logic             dreq;
  logic             starved;
  logic             err_seen;

  assign dreq    = dREN | dWEN;
  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));
  assign iload   = ramload;
  assign dload   = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ram_err    <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_cnt;
      if (err_seen) ram_err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = starve_cnt;
    iwait      = 1'b1;
    dwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    err_seen   = 1'b0;
    case (state)
      IDLE: begin
        // Saturation is implicit: a starved count with iREN pending always picks IGRANT.
        if (dreq && !(iREN && starved)) begin
          next_state = DGRANT;
          next_cnt   = iREN ? starve_cnt + 1'b1 : '0;
        end else if (iREN) begin
          next_state = IGRANT;
          next_cnt   = '0;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        err_seen = (ramstate == RAM_ERROR);
        if (!dreq) begin
          next_state = IDLE;
        end else begin
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          if (ramstate == RAM_ACCESS) begin
            dwait      = 1'b0;
            next_state = IDLE;
          end
        end
      end
      IGRANT: begin
        ramaddr  = iaddr;
        err_seen = (ramstate == RAM_ERROR);
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ramstate == RAM_ACCESS) begin
            iwait      = 1'b0;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction cache (read-only) and the data cache (read/write) in the pipelined MIPS core.
- Grants one requester at a time and holds the grant until that transaction completes.
- Data cache has priority; a starvation counter guarantees instruction fetches forward progress.
- Sits between the cache blocks and the RAM model, replacing direct cache-to-RAM wiring.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits.
- STARVE_MAX, 4, consecutive dcache grants allowed while iREN is pending before icache is forced to win.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  icache read request
- iaddr  input  ADDR_W  icache word address
- iwait  output  1  low for exactly the completing cycle of an icache read
- iload  output  DATA_W  read data to icache
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request
- daddr  input  ADDR_W  dcache word address
- dstore  input  DATA_W  dcache write data
- dwait  output  1  low for exactly the completing cycle of a dcache access
- dload  output  DATA_W  read data to dcache
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  ADDR_W  RAM address
- ramstore  output  DATA_W  RAM write data
- ramload  input  DATA_W  RAM read data
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- ram_err  output  1  sticky flag, set when ERROR is seen during a grant

Behaviour:
Reset (asynchronous, nRST low):
- State goes to IDLE and starve_cnt to 0.
- iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, ram_err=0.
- Reset asserted mid-transaction aborts it immediately; RAM enables drop in the same instant.

Data paths:
- iload and dload are wired to ramload continuously.
- Neither requester may consume data unless its wait is low.

States: IDLE, IGRANT, DGRANT (registered).

IDLE:
- RAM enables are 0 and both waits are 1.
- Arbitration is registered: a grant takes effect the cycle after the request is seen.
- Minimum latency from request to wait low is 2 cycles.
- Next state:
  - dREN|dWEN with iREN=0 -> DGRANT.
  - iREN with dREN=dWEN=0 -> IGRANT.
  - Both pending -> DGRANT, unless starve_cnt==STARVE_MAX, then IGRANT.
  - Nothing pending -> stay in IDLE.

DGRANT:
- Drive ramaddr=daddr and ramstore=dstore.
- If dWEN=1: ramWEN=1 and ramREN=0. A write wins when dWEN and dREN are both high.
- Otherwise ramREN=dREN.
- ramstate==ACCESS: dwait=0 that cycle (combinational), then -> IDLE.

IGRANT:
- Drive ramaddr=iaddr, ramREN=1, ramWEN=0.
- ramstate==ACCESS: iwait=0 that cycle, then -> IDLE.

Both grant states:
- ramstate FREE or BUSY: hold the grant and keep the waited requester's wait=1.
- ramstate ERROR: set ram_err (cleared only by reset), keep wait=1, hold the grant so the RAM retries.
- Granted requester drops its request before ACCESS (abort): RAM enables go to 0 combinationally, wait stays 1, -> IDLE next cycle.
- The non-granted requester always sees wait=1.

starve_cnt (saturates at STARVE_MAX):
- On the IDLE->DGRANT transition: increments if iREN=1, else clears to 0.
- On the IDLE->IGRANT transition: clears to 0.

Back-to-back transactions:
- Every transaction returns to IDLE for one cycle, so completion-to-next-grant has a 1-cycle bubble.
- A request that stays high after completion is re-arbitrated in that IDLE cycle.

Test Plan:
1. Icache read only: iREN=1, iaddr=0x0000_0040, RAM returns ACCESS on the 3rd grant cycle with ramload=0x2408_0001.
   - Expected: ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 only in cycle 3; iload=0x2408_0001; dwait=1 throughout.
2. Simultaneous request: iREN=1 and dREN=1 in the same cycle.
   - Expected: DGRANT first with ramaddr=daddr.
   - After dwait pulses low, one IDLE bubble, then IGRANT.
3. Starvation: iREN held high with dREN re-asserted after every completion.
   - Expected: exactly 4 dcache grants, then IGRANT on the 5th arbitration; starve_cnt returns to 0.
4. Dcache write: dWEN=1, dREN=1, daddr=0x100, dstore=0xDEAD_BEEF.
   - Expected: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
   - dwait=0 for one cycle on ACCESS.
5. Abort and error:
   - Abort: drop dREN in DGRANT before ACCESS. Expected: ramREN=0 the same cycle, IDLE the next cycle, dwait never low.
   - Error: drive ramstate=3 for 2 cycles, then ACCESS. Expected: ram_err=1 and sticky; the transaction completes normally.
6. Reset mid-transaction: assert nRST low asynchronously during IGRANT.
   - Expected: ramREN=0, iwait=1, ram_err=0 immediately.
   - After release, state is IDLE and starve_cnt=0.
